// File: rtl/rep_sync_pkg.sv
// Shared types and constants for the repetition-number sync supervisor.
package rep_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_RESET = 2'd2,
    ST_LOCK  = 2'd3
  } ch_state_e;

  localparam int unsigned MODE_PULSE = 0;
  localparam int unsigned MODE_LEVEL = 1;

  localparam int unsigned RN_W_DEF  = 8;
  localparam int unsigned CNT_W_DEF = 4;

endpackage

// File: rtl/rep_sync_supervisor_if.sv
// Receive-side compare bus and per-channel status outputs of the supervisor.
interface rep_sync_supervisor_if #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned RN_W  = 8,
  parameter int unsigned CNT_W = 4
);
  logic [N_CH-1:0]       rx_stb;
  logic [N_CH*RN_W-1:0]  crn;
  logic [N_CH*RN_W-1:0]  rn;
  logic [N_CH-1:0]       clr;
  logic [N_CH-1:0]       rst;
  logic [N_CH-1:0]       in_sync;
  logic [N_CH-1:0]       fault;
  logic [N_CH*CNT_W-1:0] mis_cnt;

  modport master (output rx_stb, crn, rn, clr, input rst, in_sync, fault, mis_cnt);
  modport slave  (input rx_stb, crn, rn, clr, output rst, in_sync, fault, mis_cnt);
endinterface

// File: rtl/rep_sync_ch.sv
// Single-channel sync supervisor: mismatch counter, resync reset FSM, retry lockout.
module rep_sync_ch
  import rep_sync_pkg::*;
#(
  parameter int unsigned RN_W      = RN_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned MAX_RX    = 11,
  parameter int unsigned MODE      = MODE_PULSE,
  parameter int unsigned RST_PULSE = 4,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_stb_i,
  input  logic [RN_W-1:0]  crn_i,
  input  logic [RN_W-1:0]  rn_i,
  input  logic             clr_i,
  output logic             rst_o,
  output logic             in_sync_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] mis_cnt_o
);

  localparam int unsigned PW  = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam int unsigned RTW = $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] MIS_LIM    = CNT_W'(MAX_RX);
  localparam logic [PW-1:0]    PULSE_LAST = PW'(RST_PULSE - 1);
  localparam logic [RTW-1:0]   RETRY_LIM  = RTW'(MAX_RETRY);

  ch_state_e        state_q;
  logic [CNT_W-1:0] mis_cnt_q;
  logic [PW-1:0]    pulse_q;
  logic [RTW-1:0]   retry_q;
  logic             rst_q;
  logic             in_sync_q;
  logic             fault_q;

  logic             match_c;
  logic [CNT_W-1:0] mis_inc_c;
  logic [RTW-1:0]   retry_inc_c;

  assign match_c     = (crn_i == rn_i);
  assign mis_inc_c   = mis_cnt_q + CNT_W'(1);
  assign retry_inc_c = retry_q + RTW'(1);

  // Leaving TRACK at the limit keeps the counter saturated at MAX_RX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mis_cnt_q <= '0;
      pulse_q   <= '0;
      retry_q   <= '0;
      rst_q     <= 1'b0;
      in_sync_q <= 1'b0;
      fault_q   <= 1'b0;
    end else if (clr_i) begin
      state_q   <= ST_IDLE;
      mis_cnt_q <= '0;
      pulse_q   <= '0;
      retry_q   <= '0;
      rst_q     <= 1'b0;
      in_sync_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_TRACK: begin
          if (rx_stb_i) begin
            state_q <= ST_TRACK;
            if (match_c) begin
              mis_cnt_q <= '0;
              in_sync_q <= 1'b1;
              retry_q   <= '0;
            end else begin
              in_sync_q <= 1'b0;
              mis_cnt_q <= mis_inc_c;
              if (mis_inc_c == MIS_LIM) begin
                state_q <= ST_RESET;
                rst_q   <= 1'b1;
                pulse_q <= '0;
              end
            end
          end
        end
        ST_RESET: begin
          if (MODE == MODE_LEVEL) begin
            if (rx_stb_i && match_c) begin
              state_q   <= ST_TRACK;
              rst_q     <= 1'b0;
              mis_cnt_q <= '0;
              in_sync_q <= 1'b1;
            end
          end else if (pulse_q == PULSE_LAST) begin
            rst_q     <= 1'b0;
            mis_cnt_q <= '0;
            retry_q   <= retry_inc_c;
            if (retry_inc_c == RETRY_LIM) begin
              state_q <= ST_LOCK;
              fault_q <= 1'b1;
            end else begin
              state_q <= ST_TRACK;
            end
          end else begin
            pulse_q <= pulse_q + PW'(1);
          end
        end
        ST_LOCK: begin
          rst_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rst_o     = rst_q;
  assign in_sync_o = in_sync_q;
  assign fault_o   = fault_q;
  assign mis_cnt_o = mis_cnt_q;

endmodule

// File: rtl/rep_sync_supervisor.sv
// N_CH independent repetition-number sync supervisors on shared packed buses.
module rep_sync_supervisor
  import rep_sync_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned RN_W      = RN_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned MAX_RX    = 11,
  parameter int unsigned MODE      = MODE_PULSE,
  parameter int unsigned RST_PULSE = 4,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rep_sync_supervisor_if.slave  bus
);

  if (N_CH < 1) begin : g_bad_n_ch
    $error("rep_sync_supervisor: N_CH must be >= 1");
  end
  if (MAX_RX < 1 || MAX_RX >= (32'd1 << CNT_W)) begin : g_bad_max_rx
    $error("rep_sync_supervisor: MAX_RX must satisfy 1 <= MAX_RX < 2**CNT_W");
  end
  if (MODE > MODE_LEVEL) begin : g_bad_mode
    $error("rep_sync_supervisor: MODE must be 0 or 1");
  end
  if (RST_PULSE < 1 || MAX_RETRY < 1) begin : g_bad_pulse_retry
    $error("rep_sync_supervisor: RST_PULSE and MAX_RETRY must be >= 1");
  end

  logic [N_CH-1:0]       rst_w;
  logic [N_CH-1:0]       in_sync_w;
  logic [N_CH-1:0]       fault_w;
  logic [N_CH*CNT_W-1:0] mis_cnt_w;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    rep_sync_ch #(
      .RN_W      (RN_W),
      .CNT_W     (CNT_W),
      .MAX_RX    (MAX_RX),
      .MODE      (MODE),
      .RST_PULSE (RST_PULSE),
      .MAX_RETRY (MAX_RETRY)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_stb_i  (bus.rx_stb[i]),
      .crn_i     (bus.crn[i*RN_W +: RN_W]),
      .rn_i      (bus.rn[i*RN_W +: RN_W]),
      .clr_i     (bus.clr[i]),
      .rst_o     (rst_w[i]),
      .in_sync_o (in_sync_w[i]),
      .fault_o   (fault_w[i]),
      .mis_cnt_o (mis_cnt_w[i*CNT_W +: CNT_W])
    );
  end

  assign bus.rst     = rst_w;
  assign bus.in_sync = in_sync_w;
  assign bus.fault   = fault_w;
  assign bus.mis_cnt = mis_cnt_w;

endmodule

// File: doc/rep_sync_supervisor.md
Name: rep_sync_supervisor

Overview:
Parametrised multi-channel supervisor for telegram repetition-number synchronisation between the buffer path and the generator path. Per channel, it compares the buffer-side repetition number (crn) against the generator-side number (rn) on every receive strobe. It counts consecutive mismatching receives. When the limit is reached, it issues a resynchronisation reset to that channel's buffer/gen pair. Adds a pulse or level reset mode, bounded retries with a sticky lockout fault, and per-channel status, all absent from the first-generation single-channel reset controller.

Parameters:
N_CH, 2, number of independent telegram channels
RN_W, 8, repetition-number width
CNT_W, 4, mismatch-counter width
MAX_RX, 11, consecutive mismatching receives that trigger reset; must satisfy 1 <= MAX_RX < 2**CNT_W
MODE, 0, 0 = pulse reset of RST_PULSE cycles; 1 = level reset held until a matching receive
RST_PULSE, 4, reset pulse length in clk cycles (MODE 0 only), >= 1
MAX_RETRY, 3, resets issued before lockout (MODE 0 only), >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_stb  in  N_CH  one-cycle strobe per channel: new telegram received from buffer module
crn  in  N_CH*RN_W  buffer-side repetition number, channel i at [i*RN_W +: RN_W]
rn  in  N_CH*RN_W  gen-side repetition number, same packing
clr  in  N_CH  per-channel fault clear strobe
rst  out  N_CH  per-channel resync reset to buffer/gen, active high
in_sync  out  N_CH  last compared receive matched
fault  out  N_CH  sticky lockout flag
mis_cnt  out  N_CH*CNT_W  current consecutive-mismatch count per channel

Behaviour:
- All channels are fully independent; there is no cross-channel interaction.
- Reset values (rst_n low, asynchronous): rst=0, in_sync=0, fault=0, mis_cnt=0, retry=0, state=IDLE. Outputs are registered.
- States per channel: IDLE, TRACK, RESET, LOCK.
- IDLE: the first rx_stb moves to TRACK, and that strobe is compared as in TRACK.
- TRACK, on rx_stb:
  - crn==rn: mis_cnt<=0, in_sync<=1.
  - mismatch: in_sync<=0, mis_cnt<=mis_cnt+1.
  - If mis_cnt+1==MAX_RX: go to RESET; rst goes high the next cycle, i.e. 1 cycle latency after the triggering strobe.
- TRACK with no rx_stb: hold all state.
- RESET, MODE 0:
  - rst high for exactly RST_PULSE cycles.
  - rx_stb is ignored.
  - On exit: mis_cnt<=0, retry<=retry+1.
  - If the new retry==MAX_RETRY: go to LOCK, else go to TRACK.
- RESET, MODE 1:
  - rst is held high.
  - rx_stb with crn==rn: rst<=0, mis_cnt<=0, in_sync<=1, go to TRACK.
  - Mismatching strobes are ignored and mis_cnt stays at MAX_RX.
  - retry, LOCK and fault are unused; fault stays 0.
- LOCK: fault=1, rst=0, rx_stb ignored. Only clr or rst_n exits.
- retry clears to 0 on any matching receive in TRACK.
- clr (any state): return to IDLE, fault<=0, rst<=0, mis_cnt<=0, retry<=0, in_sync<=0. clr wins over a simultaneous rx_stb or pulse expiry.
- mis_cnt never exceeds MAX_RX (saturating).
- Asynchronous rst_n mid-pulse: rst drops immediately, and the channel restarts in IDLE.
- Comparison is full RN_W-bit equality of the values sampled in the rx_stb cycle. Wrap-around of rn/crn has no special meaning.

Decomposition:
- Shared package rep_sync_pkg holds:
  - state enum (IDLE, TRACK, RESET, LOCK);
  - MODE_PULSE/MODE_LEVEL constants;
  - default RN_W/CNT_W.
- One sub-module, rep_sync_ch, is a single-channel FSM plus counters. The top instantiates it N_CH times in a generate loop and slices the packed buses.
- Elaboration-time assertions check the parameter ranges.

Test Plan:
- Ch0 matching strobes (crn=rn=8'h05) x20 -> in_sync=1, mis_cnt=0, rst=0 throughout.
- Ch0 11 mismatching strobes (crn=8'h05, rn=8'h06), MODE 0 -> mis_cnt reaches 10 after the 10th strobe; rst high 1 cycle after the 11th strobe for exactly 4 cycles; mis_cnt=0 afterwards.
- 10 mismatches, 1 match, 10 mismatches -> mis_cnt returns to 0 at the match; no rst ever asserted.
- 3 consecutive trigger cycles on ch1 -> three 4-cycle rst pulses, then fault[1]=1 and rst[1]=0. Further strobes are ignored. clr[1] pulse -> fault[1]=0, state IDLE. Ch0 is unaffected throughout.
- MODE 1, 11 mismatches then 5 more mismatches then 1 match -> rst high from the cycle after the 11th strobe until the cycle after the match; fault stays 0.
- rst_n asserted during the 2nd cycle of a rst pulse; clr coincident with the 11th mismatch -> rst drops asynchronously and all outputs return to reset values; with clr the channel goes to IDLE and rst never asserts.
